// File: rtl/ec1_run_ctrl.sv
// EC-1 run/load sequencer: fills program memory from a byte loader while the
// CPU is held in reset, then runs, pauses or single-steps on instruction boundaries.
module ec1_run_ctrl #(
  parameter int AW           = 4,
  parameter int DW           = 8,
  parameter int INSTR_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          run,
  input  logic          stop,
  input  logic          step,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_halt,
  output logic          cpu_rst,
  output logic          cpu_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic [2:0]    state,
  output logic          loaded,
  output logic [AW:0]   ld_count
);

  localparam int PW = (INSTR_CYCLES > 1) ? $clog2(INSTR_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(INSTR_CYCLES - 1);
  localparam logic [AW-1:0] PTR_LAST   = {AW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOAD   = 3'b001,
    S_RUN    = 3'b010,
    S_PAUSE  = 3'b011,
    S_STEP   = 3'b100,
    S_HALTED = 3'b101
  } state_t;

  state_t          cur_state, next_state;
  logic [PW-1:0]   phase;
  logic            pending;
  logic [AW-1:0]   ld_ptr;
  logic            phase_last;
  logic            load_begin;

  assign phase_last = (phase == PHASE_LAST);
  assign load_begin = (next_state == S_LOAD) && (cur_state != S_LOAD);
  assign state      = cur_state;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE: begin
        if (ld_start)            next_state = S_LOAD;
        else if (run && loaded)  next_state = S_RUN;
        else if (step && loaded) next_state = S_STEP;
      end
      S_LOAD: begin
        if (ld_valid && (ld_last || ld_ptr == PTR_LAST)) next_state = S_IDLE;
      end
      // Halt outranks both a pending pause and step completion.
      S_RUN: begin
        if (cpu_halt)                            next_state = S_HALTED;
        else if ((pending || stop) && phase_last) next_state = S_PAUSE;
      end
      S_STEP: begin
        if (cpu_halt)        next_state = S_HALTED;
        else if (phase_last) next_state = S_PAUSE;
      end
      S_PAUSE: begin
        if (ld_start)  next_state = S_LOAD;
        else if (run)  next_state = S_RUN;
        else if (step) next_state = S_STEP;
      end
      S_HALTED: begin
        if (ld_start) next_state = S_LOAD;
        else if (run) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      pending  <= 1'b0;
      ld_ptr   <= '0;
      ld_count <= '0;
      loaded   <= 1'b0;
    end else begin
      // Phase advances only while enabled and staying put; any entry or exit restarts it at 0.
      if (cpu_en && next_state == cur_state)
        phase <= phase_last ? '0 : phase + 1'b1;
      else
        phase <= '0;

      if (cur_state == S_RUN && next_state == S_RUN) pending <= pending | stop;
      else                                            pending <= 1'b0;

      if (load_begin) begin
        ld_ptr   <= '0;
        ld_count <= '0;
        loaded   <= 1'b0;
      end else if (mem_we) begin
        if (ld_ptr != PTR_LAST) ld_ptr <= ld_ptr + 1'b1;
        ld_count <= ld_count + 1'b1;
        if (next_state == S_IDLE) loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    cpu_rst   = (cur_state == S_IDLE) || (cur_state == S_LOAD);
    cpu_en    = (cur_state == S_RUN)  || (cur_state == S_STEP);
    ld_ready  = (cur_state == S_LOAD);
    mem_we    = (cur_state == S_LOAD) && ld_valid;
    mem_addr  = (cur_state == S_LOAD) ? ld_ptr : cpu_addr;
    mem_wdata = ld_data;
  end

endmodule
